// File: rtl/easyaxi_slv_wr_ctrl.sv
// AXI write-channel slave: accepts one AW/W/B transaction at a time, generates
// FIXED/INCR/WRAP beat addresses, emits each beat on a simple memory write
// port and returns a B response that flags illegal bursts and WLAST mismatches.
module easyaxi_slv_wr_ctrl #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int USER_W = 1
) (
    input  logic                clk,
    input  logic                rst,
    // AW channel
    input  logic                axi_slv_awvalid,
    output logic                axi_slv_awready,
    input  logic [ID_W-1:0]     axi_slv_awid,
    input  logic [ADDR_W-1:0]   axi_slv_awaddr,
    input  logic [LEN_W-1:0]    axi_slv_awlen,
    input  logic [2:0]          axi_slv_awsize,
    input  logic [1:0]          axi_slv_awburst,
    input  logic [USER_W-1:0]   axi_slv_awuser,
    // W channel
    input  logic                axi_slv_wvalid,
    output logic                axi_slv_wready,
    input  logic [DATA_W-1:0]   axi_slv_wdata,
    input  logic [DATA_W/8-1:0] axi_slv_wstrb,
    input  logic                axi_slv_wlast,
    input  logic [USER_W-1:0]   axi_slv_wuser,
    // B channel
    output logic                axi_slv_bvalid,
    input  logic                axi_slv_bready,
    output logic [ID_W-1:0]     axi_slv_bid,
    output logic [1:0]          axi_slv_bresp,
    output logic [USER_W-1:0]   axi_slv_buser,
    // Memory write port
    output logic                mem_wr_en,
    output logic [ADDR_W-1:0]   mem_wr_addr,
    output logic [DATA_W-1:0]   mem_wr_data,
    output logic [DATA_W/8-1:0] mem_wr_strb
);

    localparam int         STRB_W   = DATA_W / 8;
    localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_W));

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Address generation mode derived at AW accept. The reserved burst code
    // and WRAP with an unsupported length both walk addresses as INCR, so the
    // beats still land somewhere sensible while the response reports SLVERR.
    localparam logic [1:0] MODE_FIXED = 2'd0;
    localparam logic [1:0] MODE_INCR  = 2'd1;
    localparam logic [1:0] MODE_WRAP  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [2:0]        size_q;
    logic [1:0]        mode_q;
    logic [USER_W-1:0] user_q;
    logic              err_q;

    logic              aw_fire;
    logic              w_fire;
    logic              cnt_at_len;
    logic              last_beat;
    logic              wrap_len_ok;
    logic              aw_illegal;
    logic [1:0]        aw_mode;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] addr_incr;
    logic [ADDR_W-1:0] addr_next;

    // WUSER carries no meaning for this responder.
    logic unused_wuser;
    assign unused_wuser = ^axi_slv_wuser;

    assign axi_slv_awready = (state_q == ST_IDLE);
    assign axi_slv_wready  = (state_q == ST_DATA);
    assign axi_slv_bvalid  = (state_q == ST_RESP);
    assign axi_slv_bid     = id_q;
    assign axi_slv_buser   = user_q;
    assign axi_slv_bresp   = (state_q == ST_RESP && err_q) ? RESP_SLVERR : RESP_OKAY;

    assign aw_fire    = axi_slv_awvalid && axi_slv_awready;
    assign w_fire     = axi_slv_wvalid && axi_slv_wready;
    assign cnt_at_len = (cnt_q == len_q);
    assign last_beat  = axi_slv_wlast || cnt_at_len;

    assign wrap_len_ok = (axi_slv_awlen == LEN_W'(1)) || (axi_slv_awlen == LEN_W'(3)) ||
                         (axi_slv_awlen == LEN_W'(7)) || (axi_slv_awlen == LEN_W'(15));

    // Classify the incoming AW: addressing mode and whether it is legal.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        aw_mode    = MODE_INCR;
        aw_illegal = (axi_slv_awsize > SIZE_MAX);
        case (axi_slv_awburst)
            BURST_FIXED: aw_mode = MODE_FIXED;
            BURST_INCR:  aw_mode = MODE_INCR;
            BURST_WRAP: begin
                if (wrap_len_ok) begin
                    aw_mode = MODE_WRAP;
                end else begin
                    aw_illegal = 1'b1;
                end
            end
            BURST_RSVD:  aw_illegal = 1'b1;
            default:     aw_illegal = 1'b1;
        endcase
    end

    // Address of the beat after the current one.
    always_comb begin
        step      = ADDR_W'(1) << size_q;
        wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
        addr_incr = addr_q + step;
        case (mode_q)
            MODE_FIXED: addr_next = addr_q;
            MODE_WRAP:  addr_next = (addr_q & ~wrap_mask) | (addr_incr & wrap_mask);
            default:    addr_next = addr_incr;
        endcase
    end

    // Transaction sequencing: IDLE -> DATA -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (aw_fire) state_d = ST_DATA;
            ST_DATA: if (w_fire && last_beat) state_d = ST_RESP;
            ST_RESP: if (axi_slv_bready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched AW fields, beat tracking and the registered memory port.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            state_q     <= ST_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            size_q      <= '0;
            mode_q      <= MODE_FIXED;
            user_q      <= '0;
            err_q       <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_wr_strb <= '0;
        end else begin
            state_q   <= state_d;
            mem_wr_en <= w_fire;
            if (aw_fire) begin
                id_q   <= axi_slv_awid;
                addr_q <= axi_slv_awaddr;
                len_q  <= axi_slv_awlen;
                size_q <= axi_slv_awsize;
                mode_q <= aw_mode;
                user_q <= axi_slv_awuser;
                cnt_q  <= '0;
                err_q  <= aw_illegal;
            end
            if (w_fire) begin
                mem_wr_addr <= addr_q;
                mem_wr_data <= axi_slv_wdata;
                mem_wr_strb <= axi_slv_wstrb;
                addr_q      <= addr_next;
                cnt_q       <= cnt_q + LEN_W'(1);
                // WLAST must coincide exactly with the beat numbered AWLEN.
                if (axi_slv_wlast != cnt_at_len) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/easyaxi_slv_wr_ctrl.md
Name: easyaxi_slv_wr_ctrl

Overview:
AXI write-channel slave (responder) that terminates the AW/W/B channels driven by the master write controller. It accepts one write transaction at a time and computes per-beat addresses for FIXED, INCR and WRAP bursts. Each accepted beat is emitted on a simple memory write port with its strobes. It checks burst legality and WLAST alignment, then returns a B response carrying the latched ID. This is the write-side counterpart of the existing slave read controller in the top-level loopback.

Parameters:
ID_W, 4, AXI ID width
ADDR_W, 32, AXI address width
DATA_W, 32, write data width (power of 2, >= 8)
LEN_W, 8, AWLEN width
USER_W, 1, AWUSER/BUSER width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
axi_slv_awvalid  input  1  AW valid
axi_slv_awready  output  1  AW ready
axi_slv_awid  input  ID_W  AW ID
axi_slv_awaddr  input  ADDR_W  start address
axi_slv_awlen  input  LEN_W  beats minus 1
axi_slv_awsize  input  3  log2 bytes per beat
axi_slv_awburst  input  2  0 FIXED, 1 INCR, 2 WRAP
axi_slv_awuser  input  USER_W  user sideband
axi_slv_wvalid  input  1  W valid
axi_slv_wready  output  1  W ready
axi_slv_wdata  input  DATA_W  write data
axi_slv_wstrb  input  DATA_W/8  byte strobes
axi_slv_wlast  input  1  last beat
axi_slv_wuser  input  USER_W  ignored
axi_slv_bvalid  output  1  B valid
axi_slv_bready  input  1  B ready
axi_slv_bid  output  ID_W  response ID
axi_slv_bresp  output  2  00 OKAY, 10 SLVERR
axi_slv_buser  output  USER_W  latched AWUSER
mem_wr_en  output  1  one-cycle beat write pulse
mem_wr_addr  output  ADDR_W  beat address
mem_wr_data  output  DATA_W  beat data
mem_wr_strb  output  DATA_W/8  beat strobes

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. All outputs 0, except awready, which reads 1 on the first cycle after reset because it is decoded from IDLE. An in-flight transaction is dropped and no B is issued.
- FSM states: IDLE, DATA, RESP.
- IDLE:
  - awready=1, wready=0, bvalid=0.
  - On awvalid&awready: latch id, addr, len, size, burst and user; clear beat counter and error flag; go to DATA next cycle.
  - W beats presented before AW stall, because wready=0.
- DATA:
  - wready=1.
  - Each wvalid&wready beat registers mem_wr_en=1 next cycle, with mem_wr_addr = current beat address and data/strb copied from the beat.
  - The beat counter increments per beat.
- Beat address:
  - FIXED: start address every beat.
  - INCR: address + (1<<size) per beat.
  - WRAP: the increment wraps within a boundary aligned to (len+1)<<size.
  - Addresses use ADDR_W-bit modular arithmetic.
- Legality checks at AW accept; any failure sets the error flag:
  - burst==3: SLVERR, addresses treated as INCR.
  - WRAP with len not in {1,3,7,15}: SLVERR.
  - (1<<size) > DATA_W/8: SLVERR.
  - Beats are still accepted and written in all error cases.
- Termination: a beat ends DATA if wlast=1 OR counter==len.
  - If wlast=1 with counter!=len, or counter==len with wlast=0, set the error flag.
  - Next state is RESP.
- RESP:
  - bvalid=1; bid and buser are the latched values; bresp=10 if the error flag is set, else 00.
  - Outputs stay stable while bready=0.
  - On bvalid&bready, go to IDLE next cycle.
- Latency:
  - AW accept at cycle N -> wready=1 at N+1.
  - Last W at cycle M -> bvalid=1 at M+1.
  - B handshake at K -> awready=1 at K+1.
  - Minimum single-beat transaction: 3 cycles AW-to-AW.
- Ordering: one outstanding transaction; no AW is accepted during DATA or RESP.
- mem_wr_en is 0 whenever no beat was accepted in the previous cycle. mem_wr_addr/data/strb hold their last values when mem_wr_en is 0.

Test Plan:
- Single beat: AW id=3, addr=0x100, len=0, size=2, INCR; W data=0xDEADBEEF, strb=0xF, wlast=1 -> one mem write to 0x100; bvalid one cycle after the W beat with bid=3, bresp=00.
- INCR burst: addr=0x10, len=3, size=2; wvalid toggling every other cycle -> mem writes to 0x10, 0x14, 0x18, 0x1C; bresp=00 after the 4th beat.
- WRAP burst: addr=0x38, len=3, size=2 -> addresses 0x38, 0x3C, 0x30, 0x34. WRAP with len=2 -> bresp=10, all 3 beats still written.
- WLAST error: len=3 with wlast on beat 2 -> only 2 writes, bresp=10. len=1 with wlast=0 on both beats -> terminates after beat 2, bresp=10.
- Backpressure and stall: hold bready=0 for 5 cycles -> bvalid/bid/bresp stable and awready=0 throughout. W presented before AW -> wready=0 until the cycle after the AW handshake.
- Reset mid-burst: rst=1 after beat 2 of a len=7 burst -> next cycle awready=1, bvalid=0, mem_wr_en=0; a fresh transaction then completes with bresp=00.
